ps2_keyevent: RTL
=================

# ps2_keyevent

Keyboard event decoder and buffer that sits directly downstream of the epRISC PS/2 byte receiver. It consumes validated scancode-set-2 bytes and folds the E0/F0/E1 prefixes into single key events. Events are queued in a 16-entry FIFO that the CPU reads over the epRISC peripheral bus, with an optional level interrupt. Keyboard reply bytes (ACK, BAT, echo, resend, error) update status flags instead of being queued.

## Interface
- No parameters; FIFO depth fixed at 16.
- iClk  in  1  system clock.
- iRst  in  1  reset, synchronous, active-high.
- iByte  in  8  received byte, valid when iByteStb=1.
- iByteStb  in  1  one-cycle strobe, already synchronized to iClk.
- iByteErr  in  1  parity/framing error flag, qualified by iByteStb.
- iAddr  in  2  register select.
- bData  inout  32  bus; driven only when iEnable=1 and iWrite=0, else high-Z.
- iWrite  in  1  write strobe.
- iEnable  in  1  chip select.
- oInt  out  1  registered level interrupt; reset 0.

## Operation
- Registers:
  - addr0 CTRL/STAT, read/write.
    - Write bits: [0] EN, [1] IE, [2] FLUSH (self-clears), [3] CLRSTICKY (self-clears).
    - Read bits: [0] EN, [1] IE, [8] NOTEMPTY, [9] FULL, [10] OVF, [11] PERR, [12] BAT, [13] ACK, [14] RESEND, [15] KBERR, [20:16] COUNT (0..16).
  - addr1 EVENT, read pops the FIFO. Returns {NOTEMPTY at read, 21'b0, BRK[9], EXT[8], CODE[7:0]}. Returns 0 when empty; a pop of an empty FIFO is a no-op.
  - addr2 LASTBYTE: {23'b0, err, byte} of the most recent strobe, including ignored bytes.
  - addr3 ID: constant 32'h5053_0001.
- All registers reset to 0, except ID.
- Decoder FSM states: sIdle, sExt, sBrk, sExtBrk, sPause. All reset to sIdle.
  - sIdle:
    - E0 -> sExt.
    - F0 -> sBrk.
    - E1 -> sPause, skip counter = 7.
    - FA sets ACK; AA sets BAT; FE sets RESEND; 00, FC, or FF set KBERR. All stay in sIdle.
    - Any other byte pushes {0,0,byte}.
  - sExt: F0 -> sExtBrk; E0 stays in sExt; other bytes push {0,1,byte} -> sIdle.
  - sBrk: pushes {1,0,byte} -> sIdle.
  - sExtBrk: pushes {1,1,byte} -> sIdle.
  - sPause: each byte decrements the counter. When it reaches 0, push {0,1,E1} -> sIdle.
- Status bytes (FA/AA/FE/00/FC/FF) arriving in any non-sIdle state except sPause set their flag and force sIdle without a push.
- A strobe with iByteErr=1 sets PERR, discards the byte, and forces sIdle (aborts a Pause skip).
- With EN=0, strobes update only LASTBYTE; the FSM is held in sIdle.
- FIFO rules:
  - Push when full with no same-cycle pop: drop the new event and set OVF.
  - Push when full with a same-cycle pop: both succeed and COUNT is unchanged.
  - FLUSH empties the FIFO and wins over a same-cycle push/pop.
  - Sticky flags (OVF/PERR/BAT/ACK/RESEND/KBERR) clear only via CLRSTICKY or reset. A set event in the same cycle as CLRSTICKY wins.
- oInt <= IE & (NOTEMPTY | OVF | PERR).

## Timing
- Pop trigger: iEnable & !iWrite & iAddr==1, on the first cycle of the access only. Detect this with a registered previous-access bit, so a multi-cycle read pops exactly once.
- Read data is combinational from the FIFO head. The pointer advances at the clock edge ending that first cycle.
- Register writes take effect at the iClk edge where iEnable & iWrite.
- Byte latency: an iByteStb at edge N pushes at edge N+1. COUNT and NOTEMPTY are visible after N+1; oInt rises after N+2.
- Back-to-back strobes on consecutive cycles must all be processed.
- Reset mid-sequence:
  - FSM returns to sIdle and the FIFO empties.
  - The partial prefix is lost; the next byte is decoded from sIdle.
  - bData is released while iRst is held, unless a read is in progress.

## Test plan
- EN=1, bytes 1C, F0 1C -> EVENT reads 0x8000001C then 0x8000021C. The next read returns 0, and COUNT goes 2 -> 1 -> 0.
- E0 75, E0 F0 75 -> events 0x80000175, 0x80000375. E1 14 77 E1 F0 14 F0 77 -> exactly one event, 0x800001E1.
- 17 make bytes with no reads -> FULL=1, OVF=1, COUNT=16, and the 17th byte is lost. CLRSTICKY clears OVF; FLUSH sets COUNT to 0.
- Bytes AA then FA -> BAT=1, ACK=1, COUNT=0. F0 followed by a strobe with iByteErr=1 -> PERR=1, FSM in sIdle; the next byte 1C yields a make event.
- IE=1, one byte -> oInt=1 two cycles after the strobe. A 3-cycle read pops once, and oInt falls after COUNT reaches 0.
- Full FIFO with a simultaneous pop and push -> COUNT stays 16, OVF stays 0, and head order is preserved.

Source files
------------

// File: rtl/ps2_keyevent.sv
// PS/2 scancode-set-2 event decoder: folds E0/F0/E1 prefixes into key events,
// queues them in a 16-deep FIFO and exposes status/event registers on the peripheral bus.
module ps2_keyevent (
   input  logic        iClk,
   input  logic        iRst,
   input  logic [7:0]  iByte,
   input  logic        iByteStb,
   input  logic        iByteErr,
   input  logic [1:0]  iAddr,
   inout  wire  [31:0] bData,
   input  logic        iWrite,
   input  logic        iEnable,
   output logic        oInt
);

   typedef enum logic [2:0] {sIdle, sExt, sBrk, sExtBrk, sPause} state_t;

   localparam logic [31:0] ID_VALUE = 32'h5053_0001;

   state_t      state_q;
   logic [2:0]  skip_q;
   logic        push_q;
   logic [9:0]  ev_q;
   logic        set_ack_q, set_bat_q, set_resend_q, set_kberr_q, set_perr_q;

   logic        en_q, en_d;
   logic        ie_q, ie_d;
   logic        ovf_q, ovf_d;
   logic        perr_q, perr_d;
   logic        bat_q, bat_d;
   logic        ack_q, ack_d;
   logic        resend_q, resend_d;
   logic        kberr_q, kberr_d;
   logic        int_q, int_d;
   logic        rd_prev_q, rd_prev_d;
   logic [8:0]  lastbyte_q, lastbyte_d;
   logic [3:0]  wr_ptr_q, wr_ptr_d;
   logic [3:0]  rd_ptr_q, rd_ptr_d;
   logic [4:0]  count_q, count_d;

   logic [9:0]  mem [16];

   logic        wr_ctrl, rd_access, pop_req, flush, clr_sticky;
   logic        not_empty, full, do_pop, do_push;
   logic [31:0] rd_data;
   logic        unused_wr_bits;

   function automatic logic is_status(input logic [7:0] b);
      return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hFE) ||
             (b == 8'h00) || (b == 8'hFC) || (b == 8'hFF);
   endfunction

   // Decoder runs on the raw strobe; its registered push lands in the FIFO one edge later.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q      <= sIdle;
         skip_q       <= 3'd0;
         push_q       <= 1'b0;
         ev_q         <= 10'd0;
         set_ack_q    <= 1'b0;
         set_bat_q    <= 1'b0;
         set_resend_q <= 1'b0;
         set_kberr_q  <= 1'b0;
         set_perr_q   <= 1'b0;
      end else begin
         push_q       <= 1'b0;
         set_ack_q    <= 1'b0;
         set_bat_q    <= 1'b0;
         set_resend_q <= 1'b0;
         set_kberr_q  <= 1'b0;
         set_perr_q   <= 1'b0;
         if (!en_q) begin
            state_q <= sIdle;
         end else if (iByteStb) begin
            if (iByteErr) begin
               set_perr_q <= 1'b1;
               state_q    <= sIdle;
            end else if (state_q == sPause) begin
               skip_q <= skip_q - 3'd1;
               if (skip_q == 3'd1) begin
                  push_q  <= 1'b1;
                  ev_q    <= {2'b01, 8'hE1};
                  state_q <= sIdle;
               end
            end else if (is_status(iByte)) begin
               set_ack_q    <= (iByte == 8'hFA);
               set_bat_q    <= (iByte == 8'hAA);
               set_resend_q <= (iByte == 8'hFE);
               set_kberr_q  <= (iByte == 8'h00) || (iByte == 8'hFC) || (iByte == 8'hFF);
               state_q      <= sIdle;
            end else begin
               case (state_q)
                  sIdle: begin
                     if (iByte == 8'hE0) begin
                        state_q <= sExt;
                     end else if (iByte == 8'hF0) begin
                        state_q <= sBrk;
                     end else if (iByte == 8'hE1) begin
                        state_q <= sPause;
                        skip_q  <= 3'd7;
                     end else begin
                        push_q <= 1'b1;
                        ev_q   <= {2'b00, iByte};
                     end
                  end
                  sExt: begin
                     if (iByte == 8'hF0) begin
                        state_q <= sExtBrk;
                     end else if (iByte != 8'hE0) begin
                        push_q  <= 1'b1;
                        ev_q    <= {2'b01, iByte};
                        state_q <= sIdle;
                     end
                  end
                  sBrk: begin
                     push_q  <= 1'b1;
                     ev_q    <= {2'b10, iByte};
                     state_q <= sIdle;
                  end
                  sExtBrk: begin
                     push_q  <= 1'b1;
                     ev_q    <= {2'b11, iByte};
                     state_q <= sIdle;
                  end
                  default: state_q <= sIdle;
               endcase
            end
         end
      end
   end

   assign wr_ctrl    = iEnable & iWrite & (iAddr == 2'd0);
   assign rd_access  = iEnable & ~iWrite & (iAddr == 2'd1);
   assign pop_req    = rd_access & ~rd_prev_q;
   assign flush      = wr_ctrl & bData[2];
   assign clr_sticky = wr_ctrl & bData[3];
   assign not_empty  = (count_q != 5'd0);
   assign full       = (count_q == 5'd16);
   assign do_pop     = pop_req & not_empty;
   assign do_push    = push_q & (~full | do_pop);
   assign unused_wr_bits = ^bData[31:4];

   always_comb begin
      en_d       = en_q;
      ie_d       = ie_q;
      ovf_d      = ovf_q;
      perr_d     = perr_q;
      bat_d      = bat_q;
      ack_d      = ack_q;
      resend_d   = resend_q;
      kberr_d    = kberr_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_prev_d  = rd_access;
      lastbyte_d = iByteStb ? {iByteErr, iByte} : lastbyte_q;
      int_d      = ie_q & (not_empty | ovf_q | perr_q);

      if (wr_ctrl) begin
         en_d = bData[0];
         ie_d = bData[1];
      end

      if (flush) begin
         wr_ptr_d = 4'd0;
         rd_ptr_d = 4'd0;
         count_d  = 5'd0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 4'd1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 4'd1;
         count_d = count_q + {4'd0, do_push} - {4'd0, do_pop};
      end

      // Clear first so a same-cycle set survives.
      if (clr_sticky) begin
         ovf_d    = 1'b0;
         perr_d   = 1'b0;
         bat_d    = 1'b0;
         ack_d    = 1'b0;
         resend_d = 1'b0;
         kberr_d  = 1'b0;
      end
      if (push_q & full & ~do_pop & ~flush) ovf_d = 1'b1;
      if (set_perr_q)   perr_d   = 1'b1;
      if (set_bat_q)    bat_d    = 1'b1;
      if (set_ack_q)    ack_d    = 1'b1;
      if (set_resend_q) resend_d = 1'b1;
      if (set_kberr_q)  kberr_d  = 1'b1;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         en_q       <= 1'b0;
         ie_q       <= 1'b0;
         ovf_q      <= 1'b0;
         perr_q     <= 1'b0;
         bat_q      <= 1'b0;
         ack_q      <= 1'b0;
         resend_q   <= 1'b0;
         kberr_q    <= 1'b0;
         int_q      <= 1'b0;
         rd_prev_q  <= 1'b0;
         lastbyte_q <= 9'd0;
         wr_ptr_q   <= 4'd0;
         rd_ptr_q   <= 4'd0;
         count_q    <= 5'd0;
      end else begin
         en_q       <= en_d;
         ie_q       <= ie_d;
         ovf_q      <= ovf_d;
         perr_q     <= perr_d;
         bat_q      <= bat_d;
         ack_q      <= ack_d;
         resend_q   <= resend_d;
         kberr_q    <= kberr_d;
         int_q      <= int_d;
         rd_prev_q  <= rd_prev_d;
         lastbyte_q <= lastbyte_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst && do_push && !flush) mem[wr_ptr_q] <= ev_q;
   end

   always_comb begin
      rd_data = 32'd0;
      case (iAddr)
         2'd0: rd_data = {11'd0, count_q, kberr_q, resend_q, ack_q, bat_q, perr_q, ovf_q,
                          full, not_empty, 6'd0, ie_q, en_q};
         2'd1: rd_data = not_empty ? {1'b1, 21'd0, mem[rd_ptr_q]} : 32'd0;
         2'd2: rd_data = {23'd0, lastbyte_q};
         default: rd_data = ID_VALUE;
      endcase
   end

   assign bData = (iEnable & ~iWrite) ? rd_data : 32'bz;
   assign oInt  = int_q;

endmodule
